// File: rtl/pwm_burst_source_pkg.sv
// ---------------------------------------------------------------------------
// pwm_burst_source_pkg
//   Shared constants and types for the 40 kHz PWM burst source and any later
//   PWM / phase logic that has to agree with its period.
//   - PWM_PERIOD / PWM_CTR_W : clocks per PWM period and counter width
//   - PWM_SAMPLE_W           : ADC sample width
//   - ADC_CHANNEL_DEF        : ADC channel accepted by default
//   - BURST_ON_DEF / _OFF_DEF: default burst gating lengths in periods
//   - burst_state_e          : burst gating FSM states
//   - burst_cnt_width()      : width of the period counter used by the FSM
// ---------------------------------------------------------------------------
package pwm_burst_source_pkg;

  localparam int PWM_PERIOD   = 1250;
  localparam int PWM_CTR_W    = 11;
  localparam int PWM_SAMPLE_W = 10;

  localparam logic [3:0] ADC_CHANNEL_DEF = 4'd0;

  localparam int BURST_ON_DEF  = 8;
  localparam int BURST_OFF_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONT  = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } burst_state_e;

  // Enough bits to count 0..max(on,off)-1; never narrower than one bit.
  function automatic int burst_cnt_width(input int on_periods, input int off_periods);
    int longest;
    longest = (on_periods > off_periods) ? on_periods : off_periods;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/pwm_burst_source_duty_scaler.sv
// ---------------------------------------------------------------------------
// pwm_burst_source_duty_scaler
//   Turns an accepted ADC sample into a PWM compare value:
//     pending = (sample * PERIOD) >> SAMPLE_W   (unsigned, truncating)
//   The multiply is registered, then the shifted result lands in pending_q,
//   so a sample reaches pending_q two edges after its strobe. Samples from
//   any channel other than ADC_CHANNEL leave both stages untouched.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   new_sample       : one-cycle strobe qualifying sample / sample_channel
//   sample           : unsigned ADC result
//   sample_channel   : ADC channel tag of sample
//   pending_q        : compare value waiting for the next period boundary
// ---------------------------------------------------------------------------
module pwm_burst_source_duty_scaler
  import pwm_burst_source_pkg::*;
#(
  parameter int         PERIOD      = PWM_PERIOD,
  parameter int         CTR_W       = PWM_CTR_W,
  parameter int         SAMPLE_W    = PWM_SAMPLE_W,
  parameter logic [3:0] ADC_CHANNEL = ADC_CHANNEL_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [3:0]          sample_channel,
  output logic [CTR_W-1:0]    pending_q
);

  localparam int                PROD_W   = SAMPLE_W + CTR_W;
  localparam logic [PROD_W-1:0] PERIOD_P = PROD_W'(PERIOD);

  logic              prod_vld_q, prod_vld_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CTR_W-1:0]  pending_d;

  // Next-state for the multiply stage and the pending compare value.
  always_comb begin
    prod_vld_d = new_sample && (sample_channel == ADC_CHANNEL);
    if (prod_vld_d) begin
      prod_d = PROD_W'(sample) * PERIOD_P;
    end else begin
      prod_d = prod_q;
    end
    if (prod_vld_q) begin
      pending_d = CTR_W'(prod_q >> SAMPLE_W);
    end else begin
      pending_d = pending_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      pending_q  <= '0;
    end else begin
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: rtl/pwm_burst_source.sv
// ---------------------------------------------------------------------------
// pwm_burst_source
//   40 kHz PWM source for the phased delay line, with optional tone bursts.
//   A free-running period counter sets the phase; the duty comes from the
//   ADC via the duty scaler and is only adopted at the period wrap, as are
//   all enable / burst_mode decisions, so every emitted period is whole.
// Ports:
//   clk, rst_n      : 50 MHz clock, async active-low reset
//   new_sample      : one-cycle strobe qualifying sample / sample_channel
//   sample          : unsigned ADC result
//   sample_channel  : ADC channel tag of sample
//   enable          : level, high = produce output
//   burst_mode      : high = BURST_ON on / BURST_OFF off, low = continuous
//   pwm_out         : registered PWM to the delay line
//   period_start    : one-cycle pulse on the first clock of each period
//   burst_active    : registered, high while the FSM is in BURST
// ---------------------------------------------------------------------------
module pwm_burst_source
  import pwm_burst_source_pkg::*;
#(
  parameter int         PERIOD      = PWM_PERIOD,
  parameter int         CTR_W       = PWM_CTR_W,
  parameter int         SAMPLE_W    = PWM_SAMPLE_W,
  parameter logic [3:0] ADC_CHANNEL = ADC_CHANNEL_DEF,
  parameter int         BURST_ON    = BURST_ON_DEF,
  parameter int         BURST_OFF   = BURST_OFF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [3:0]          sample_channel,
  input  logic                enable,
  input  logic                burst_mode,
  output logic                pwm_out,
  output logic                period_start,
  output logic                burst_active
);

  localparam int               BCNT_W    = burst_cnt_width(BURST_ON, BURST_OFF);
  localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(PERIOD - 1);
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [BCNT_W-1:0] ON_LAST  = BCNT_W'(BURST_ON - 1);
  localparam logic [BCNT_W-1:0] OFF_LAST = BCNT_W'(BURST_OFF - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = {BCNT_W{1'b1}};

  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [CTR_W-1:0]  active_q, active_d;
  logic [CTR_W-1:0]  pending_s;
  burst_state_e      state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BCNT_W-1:0] bcnt_inc_s;
  logic              pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              burst_active_q, burst_active_d;
  logic              wrap_s;
  logic              gate_s;

  pwm_burst_source_duty_scaler #(
    .PERIOD      (PERIOD),
    .CTR_W       (CTR_W),
    .SAMPLE_W    (SAMPLE_W),
    .ADC_CHANNEL (ADC_CHANNEL)
  ) u_duty_scaler (
    .clk            (clk),
    .rst_n          (rst_n),
    .new_sample     (new_sample),
    .sample         (sample),
    .sample_channel (sample_channel),
    .pending_q      (pending_s)
  );

  // Counter, compare latch, burst FSM and output next-state.
  always_comb begin
    wrap_s = (ctr_q == CTR_LAST);

    if (wrap_s) begin
      ctr_d    = '0;
      active_d = pending_s;
    end else begin
      ctr_d    = ctr_q + CTR_ONE;
      active_d = active_q;
    end

    // Saturate rather than wrap if a state ever overstays its count.
    if (bcnt_q == BCNT_MAX) begin
      bcnt_inc_s = bcnt_q;
    end else begin
      bcnt_inc_s = bcnt_q + BCNT_ONE;
    end

    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (wrap_s) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = burst_mode ? ST_BURST : ST_CONT;
            bcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CONT: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (burst_mode) begin
            state_d = ST_BURST;
            bcnt_d  = '0;
          end else begin
            state_d = ST_CONT;
          end
        end
        ST_BURST: begin
          if (!enable) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end else if (bcnt_q == ON_LAST) begin
            state_d = ST_GAP;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_inc_s;
          end
        end
        ST_GAP: begin
          if (!enable) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end else if (!burst_mode) begin
            state_d = ST_CONT;
            bcnt_d  = '0;
          end else if (bcnt_q == OFF_LAST) begin
            state_d = ST_BURST;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_inc_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    gate_s         = (state_q == ST_BURST) || (state_q == ST_CONT);
    pwm_d          = gate_s && (ctr_q < active_q);
    period_start_d = (ctr_q == '0);
    burst_active_d = (state_q == ST_BURST);
  end

  // All state and the registered outputs; reset clears outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q          <= '0;
      active_q       <= '0;
      state_q        <= ST_IDLE;
      bcnt_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      burst_active_q <= 1'b0;
    end else begin
      ctr_q          <= ctr_d;
      active_q       <= active_d;
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      burst_active_q <= burst_active_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign burst_active = burst_active_q;

endmodule
